zrle_dbx_encoder: RTL and testbench
===================================

ZRLE_DBX_ENCODER -- requirements
Module: zrle_dbx_encoder

Interface
REQ-001 SHALL take parameters from ebpc_pkg: DATA_W (symbol word width), LOG_DATA_W (zero-run field width), BLOCK_SIZE (DBX/DBP width + 1); no module-local parameters.
REQ-002 SHALL have one clock; reset is synchronous and active-high: clk_i input 1 (rising-edge clock), then rst_i input 1 (synchronous active-high reset).
REQ-003 SHALL have dbx_i input BLOCK_SIZE-1 (delta-bitplane-XOR word), dbp_i input BLOCK_SIZE-1 (delta-bitplane word), last_i input 1 (final plane of block).
REQ-004 SHALL have in_valid_i input 1 and in_ready_o output 1 (input handshake).
REQ-005 SHALL have data_o output DATA_W (symbol, MSB-aligned, unused LSBs zero), len_o output symb_len_t (symbol length code), last_o output 1 (final symbol of block).
REQ-006 SHALL have out_valid_o output 1 and out_ready_i input 1 (output handshake).

Function
REQ-007 SHALL transfer on valid&&ready at a rising edge; out_valid_o SHALL not drop, and data_o/len_o/last_o SHALL stay stable, until accepted.
REQ-008 SHALL classify each accepted word in priority order: dbx==0 -> zero; dbx all-ones -> '00000', FIVE; dbp==0 -> '00001', FIVE; dbx=={2'b11,0..}>>p -> '00010'+p, FIVE_PLUS_LOGN; dbx=={1'b1,0..}>>p -> '00011'+p, FIVE_PLUS_LOGN; else '1'+dbx, N.
REQ-009 SHALL encode p on $clog2(BLOCK_SIZE-1) bits, counted from MSB of dbx.
REQ-010 SHALL hold a zero-run counter cnt, width LOG_DATA_W+1, range 0..2^LOG_DATA_W.
REQ-011 SHALL encode a run of length r as '01', TWO when r==1, else '001'+(r-1) on LOG_DATA_W bits, THREE_PLUS_LOGM.
REQ-012 SHALL use FSM states IDLE (cnt==0), RUN (cnt>0), PEND (run symbol in output register, nonzero word held).
REQ-013 Zero word, not last: cnt+1; if cnt+1==2^LOG_DATA_W emit run symbol, cnt=0, go IDLE; else no output, go RUN.
REQ-014 Zero word with last_i: emit run symbol for cnt+1 with last_o=1, cnt=0, go IDLE.
REQ-015 Nonzero word in IDLE: emit its symbol with last_o=last_i, one-cycle latency.
REQ-016 Nonzero word in RUN: emit run symbol (last_o=0), latch word symbol and last_i, cnt=0, go PEND; in PEND, when output slot frees, emit latched symbol, go IDLE.
REQ-017 in_ready_o SHALL equal (!out_valid_o || out_ready_i) && state!=PEND; combinational from out_ready_i, no path from in_valid_i.
REQ-018 SHALL sustain one input per cycle when out_ready_i=1 and no PEND stalls.
REQ-019 SHALL never output a run symbol with r==0 nor r>2^LOG_DATA_W.

Reset
REQ-020 rst_i SHALL clear out_valid_o=0, data_o=0, len_o=N, last_o=0, cnt=0, state IDLE, pending register cleared; in-flight run discarded, no symbol emitted.
REQ-021 rst_i SHALL take priority over any simultaneous handshake.

Structure
REQ-022 symb_len_t, DATA_W, LOG_DATA_W, BLOCK_SIZE SHALL stay in ebpc_pkg; a state enum typedef SHALL be local.
REQ-023 Classification (REQ-008/009) SHALL be a combinational sub-module dbx_symbol_classifier; counter, FSM, output register in zrle_dbx_encoder.

Verification (BLOCK_SIZE=8, DATA_W=8, LOG_DATA_W=3)
REQ-024 dbx=0 x3, then dbx=7'b1111111 last -> '001'+3'b010 len THREE_PLUS_LOGM last_o=0, then '00000' len FIVE last_o=1.
REQ-025 single dbx=0 last -> data_o=8'b01000000, TWO, last_o=1.
REQ-026 dbx=7'b0011000, dbp!=0 -> 8'b00010010, FIVE_PLUS_LOGN; dbx=7'b1010101, dbp!=0 -> 8'b11010101, N.
REQ-027 9 zeros, then dbx=7'b1010101 last -> '001'+3'b111 after 8th; '01' then '1'+1010101 last_o=1; in_ready_o=0 one cycle in PEND.
REQ-028 out_ready_i=0 for 5 cycles -> data_o/len_o stable, in_ready_o=0, no loss; dbx=7'b0100100, dbp=0 -> '00001', FIVE.
REQ-029 rst_i during RUN with cnt=5 -> no symbol, next dbx=0 last yields '01'.

Source files
------------

// File: rtl/ebpc_pkg.sv
// Shared widths and symbol types for the bitplane compressor encoders.
package ebpc_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned LOG_DATA_W = 3;
  localparam int unsigned BLOCK_SIZE = 8;

  typedef enum logic [2:0] {
    TWO,
    THREE_PLUS_LOGM,
    FIVE,
    FIVE_PLUS_LOGN,
    N
  } symb_len_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    symb_len_t         len;
  } symb_t;

endpackage

// File: rtl/dbx_symbol_classifier.sv
// Maps one DBX/DBP word to its MSB-aligned symbol and length code; purely
// combinational (zero latency), no handshake.
module dbx_symbol_classifier
  import ebpc_pkg::*;
(
  input  logic [BLOCK_SIZE-2:0] dbx_i,
  input  logic [BLOCK_SIZE-2:0] dbp_i,
  output logic                  zero_o,
  output symb_t                 symb_o
);

  localparam int unsigned W    = BLOCK_SIZE - 1;
  localparam int unsigned LOGN = $clog2(W);
  localparam logic [W-1:0] ONE_HOT = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] TWO_HOT = {2'b11, {(W-2){1'b0}}};

  logic            is_two;
  logic            is_one;
  logic [LOGN-1:0] pos;

  // Two-hot and one-hot patterns never coexist, so they can share pos.
  always_comb begin
    is_two = 1'b0;
    is_one = 1'b0;
    pos    = '0;
    for (int p = 0; p < W - 1; p++) begin
      if (dbx_i == (TWO_HOT >> p)) begin
        is_two = 1'b1;
        pos    = LOGN'(p);
      end
    end
    for (int p = 0; p < W; p++) begin
      if (dbx_i == (ONE_HOT >> p)) begin
        is_one = 1'b1;
        pos    = LOGN'(p);
      end
    end
  end

  always_comb begin
    zero_o      = (dbx_i == '0);
    symb_o.data = '0;
    symb_o.len  = N;
    if (dbx_i == '1) begin
      symb_o.len = FIVE;
    end else if (dbp_i == '0) begin
      symb_o.data[DATA_W-1 -: 5] = 5'b00001;
      symb_o.len                 = FIVE;
    end else if (is_two) begin
      symb_o.data[DATA_W-1 -: 5]    = 5'b00010;
      symb_o.data[DATA_W-6 -: LOGN] = pos;
      symb_o.len                    = FIVE_PLUS_LOGN;
    end else if (is_one) begin
      symb_o.data[DATA_W-1 -: 5]    = 5'b00011;
      symb_o.data[DATA_W-6 -: LOGN] = pos;
      symb_o.len                    = FIVE_PLUS_LOGN;
    end else begin
      symb_o.data = DATA_W'({1'b1, dbx_i}) << (DATA_W - BLOCK_SIZE);
      symb_o.len  = N;
    end
  end

endmodule

// File: rtl/zrle_dbx_encoder.sv
// Zero-run-length + DBX symbol encoder: one-cycle latency; a nonzero word ending a
// run costs one extra cycle (PEND); input stalls while the output register is held.
module zrle_dbx_encoder
  import ebpc_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [BLOCK_SIZE-2:0] dbx_i,
  input  logic [BLOCK_SIZE-2:0] dbp_i,
  input  logic                  last_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_W-1:0]     data_o,
  output symb_len_t             len_o,
  output logic                  last_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  localparam int unsigned CNT_W = LOG_DATA_W + 1;
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(1) << LOG_DATA_W;
  localparam symb_t SYMB_RST = '{data: '0, len: N};

  function automatic symb_t run_symbol(input logic [CNT_W-1:0] r);
    symb_t s;
    s.data = '0;
    if (r == CNT_W'(1)) begin
      s.data[DATA_W-1 -: 2] = 2'b01;
      s.len                 = TWO;
    end else begin
      s.data[DATA_W-1 -: 3]          = 3'b001;
      s.data[DATA_W-4 -: LOG_DATA_W] = LOG_DATA_W'(r - CNT_W'(1));
      s.len                          = THREE_PLUS_LOGM;
    end
    return s;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             out_vld_q, out_vld_d;
  symb_t            out_q, out_d;
  logic             out_last_q, out_last_d;
  symb_t            pend_q, pend_d;
  logic             pend_last_q, pend_last_d;

  logic  word_zero;
  symb_t word_symb;
  logic  slot_free;
  logic  accept;

  dbx_symbol_classifier u_classifier (
    .dbx_i  (dbx_i),
    .dbp_i  (dbp_i),
    .zero_o (word_zero),
    .symb_o (word_symb)
  );

  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign slot_free  = !out_vld_q || out_ready_i;
  assign in_ready_o = slot_free && (state_q != PEND);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_vld_d   = out_vld_q;
    out_d       = out_q;
    out_last_d  = out_last_q;
    pend_d      = pend_q;
    pend_last_d = pend_last_q;
    if (out_vld_q && out_ready_i) out_vld_d = 1'b0;

    if (state_q == PEND) begin
      if (slot_free) begin
        out_vld_d  = 1'b1;
        out_d      = pend_q;
        out_last_d = pend_last_q;
        state_d    = IDLE;
      end
    end else if (accept) begin
      if (word_zero) begin
        // A full counter flushes early so a run never exceeds 2^LOG_DATA_W.
        if (last_i || (cnt_inc == RUN_MAX)) begin
          out_vld_d  = 1'b1;
          out_d      = run_symbol(cnt_inc);
          out_last_d = last_i;
          cnt_d      = '0;
          state_d    = IDLE;
        end else begin
          cnt_d   = cnt_inc;
          state_d = RUN;
        end
      end else if (state_q == IDLE) begin
        out_vld_d  = 1'b1;
        out_d      = word_symb;
        out_last_d = last_i;
      end else begin
        out_vld_d   = 1'b1;
        out_d       = run_symbol(cnt_q);
        out_last_d  = 1'b0;
        pend_d      = word_symb;
        pend_last_d = last_i;
        cnt_d       = '0;
        state_d     = PEND;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_vld_q   <= 1'b0;
      out_q       <= SYMB_RST;
      out_last_q  <= 1'b0;
      pend_q      <= SYMB_RST;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_vld_q   <= out_vld_d;
      out_q       <= out_d;
      out_last_q  <= out_last_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
    end
  end

  assign data_o      = out_q.data;
  assign len_o       = out_q.len;
  assign last_o      = out_last_q;
  assign out_valid_o = out_vld_q;

endmodule

// File: tb/tb_zrle_dbx_encoder.sv
// Directed and randomized bench for zrle_dbx_encoder against a symbol-list model.
module tb_zrle_dbx_encoder;
  import ebpc_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [6:0] dbx_i = '0;
  logic [6:0] dbp_i = '0;
  logic       last_i = 1'b0;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o;
  logic [7:0] data_o;
  symb_len_t  len_o;
  logic       last_o;
  logic       out_valid_o;
  logic       out_ready_i = 1'b1;

  zrle_dbx_encoder dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .dbx_i       (dbx_i),
    .dbp_i       (dbp_i),
    .last_i      (last_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .data_o      (data_o),
    .len_o       (len_o),
    .last_o      (last_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] d;
    symb_len_t  l;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   m_run = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   ready_ctl = 0;
  int   last_wait = 0;

  // 0: always ready, 1: random backpressure, 2: hold off.
  always @(posedge clk_i) begin
    #1;
    case (ready_ctl)
      0:       out_ready_i = 1'b1;
      1:       out_ready_i = ($urandom_range(0, 3) != 0);
      default: out_ready_i = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t run_exp(input int r);
    exp_t e;
    e.last = 1'b0;
    if (r == 1) begin
      e.d = 8'h40;
      e.l = TWO;
    end else begin
      e.d = 8'(32 + (r - 1) * 4);
      e.l = THREE_PLUS_LOGM;
    end
    return e;
  endfunction

  function automatic exp_t word_exp(input logic [6:0] x, input logic [6:0] p);
    exp_t e;
    int   n;
    int   lead;
    e.last = 1'b0;
    n      = $countones(x);
    lead   = 7;
    for (int i = 0; i < 7; i++) if (lead == 7 && x[6-i]) lead = i;
    if (x == 7'h7f) begin
      e.d = 8'h00; e.l = FIVE;
    end else if (p == 7'h00) begin
      e.d = 8'h08; e.l = FIVE;
    end else if (n == 2 && lead < 6 && x[5-lead]) begin
      e.d = 8'(16 + lead); e.l = FIVE_PLUS_LOGN;
    end else if (n == 1) begin
      e.d = 8'(24 + lead); e.l = FIVE_PLUS_LOGN;
    end else begin
      e.d = {1'b1, x}; e.l = N;
    end
    return e;
  endfunction

  task automatic model_accept(input logic [6:0] x, input logic [6:0] p, input logic l);
    exp_t e;
    if (x == 7'h00) begin
      m_run++;
      if (l || m_run == 8) begin
        e = run_exp(m_run);
        e.last = l;
        exp_q.push_back(e);
        m_run = 0;
      end
    end else begin
      if (m_run > 0) begin
        exp_q.push_back(run_exp(m_run));
        m_run = 0;
      end
      e = word_exp(x, p);
      e.last = l;
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [6:0] x, input logic [6:0] p, input logic l);
    bit done = 1'b0;
    int waited = 0;
    dbx_i = x; dbp_i = p; last_i = l; in_valid_i = 1'b1;
    while (!done) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        model_accept(x, p, l);
        done = 1'b1;
      end else if (++waited > 200) begin
        vectors++;
        miscompares++;
        $error("FAIL send_timeout: in_ready_o stuck low for %0d cycles", waited);
        done = 1'b1;
      end
      @(posedge clk_i);
      #1;
    end
    in_valid_i = 1'b0;
    last_wait  = waited;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk_i);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  // Output monitor: compares every accepted symbol and the hold-while-stalled rule.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d;
  symb_len_t  prev_l;
  logic       prev_last;

  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid_o), 32'd1);
        check("hold_data", 32'(data_o), 32'(prev_d));
        check("hold_len", 32'(len_o), 32'(prev_l));
        check("hold_last", 32'(last_o), 32'(prev_last));
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $error("FAIL unexpected_symbol: observed data %0h len %0d, expected none", data_o, len_o);
        end else begin
          e = exp_q.pop_front();
          check("sym_data", 32'(data_o), 32'(e.d));
          check("sym_len", 32'(len_o), 32'(e.l));
          check("sym_last", 32'(last_o), 32'(e.last));
        end
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_d     = data_o;
      prev_l     = len_o;
      prev_last  = last_o;
    end
  end

  initial begin
    logic [6:0] x;
    logic [6:0] p;
    logic       l;

    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_len", 32'(len_o), 32'(N));
    check("rst_last", 32'(last_o), 32'd0);
    check("rst_in_ready", 32'(in_ready_o), 32'd1);
    @(posedge clk_i);
    #1;

    // Three zeros then an all-ones final plane.
    repeat (3) send(7'h00, 7'h15, 1'b0);
    send(7'h7f, 7'h15, 1'b1);
    drain();

    // Lone zero final plane.
    send(7'h00, 7'h00, 1'b1);
    drain();

    // Two-hot and raw words, back to back.
    send(7'b0011000, 7'h22, 1'b0);
    send(7'b1010101, 7'h22, 1'b0);
    check("full_rate_accept", 32'(last_wait), 32'd0);
    drain();

    // Nine zeros: one full run flush, then a short run ended by a raw word.
    repeat (9) send(7'h00, 7'h01, 1'b0);
    send(7'b1010101, 7'h33, 1'b1);
    @(negedge clk_i);
    check("pend_in_ready_low", 32'(in_ready_o), 32'd0);
    @(negedge clk_i);
    check("pend_in_ready_back", 32'(in_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    drain();

    // Output held off for five cycles with a word waiting at the input.
    ready_ctl = 2;
    @(posedge clk_i);
    #2;
    send(7'b0100100, 7'h00, 1'b0);
    dbx_i = 7'b1010101; dbp_i = 7'h11; last_i = 1'b1; in_valid_i = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      check("stall_in_ready", 32'(in_ready_o), 32'd0);
    end
    ready_ctl = 0;
    send(7'b1010101, 7'h11, 1'b1);
    drain();

    // Reset in the middle of a five-zero run drops the run.
    repeat (5) send(7'h00, 7'h05, 1'b0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    m_run = 0;
    exp_q.delete();
    @(negedge clk_i);
    check("mid_run_rst_valid", 32'(out_valid_o), 32'd0);
    @(posedge clk_i);
    #1;
    send(7'h00, 7'h05, 1'b1);
    drain();

    // Randomized words under random backpressure.
    ready_ctl = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    x = 7'h00;
        2:       x = 7'h7f;
        3:       x = 7'h60 >> $urandom_range(0, 5);
        4:       x = 7'h40 >> $urandom_range(0, 6);
        default: x = 7'($urandom);
      endcase
      p = ($urandom_range(0, 4) == 0) ? 7'h00 : 7'($urandom_range(1, 127));
      l = ($urandom_range(0, 6) == 0);
      send(x, p, l);
    end
    ready_ctl = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
